// File: rtl/mdu_pkg.sv
// Shared types and constants for the E-stage multiply/divide sequencer.
// Optional build macro: MDU_MADD_EN enables the madd/maddu/msub/msubu family.
package mdu_pkg;

  typedef enum logic [3:0] {
    MDU_NONE = 4'd0,
    MULT     = 4'd1,
    MULTU    = 4'd2,
    DIV      = 4'd3,
    DIVU     = 4'd4,
    MTHI     = 4'd5,
    MTLO     = 4'd6,
    MFHI     = 4'd7,
    MFLO     = 4'd8,
    MADD     = 4'd9,
    MADDU    = 4'd10,
    MSUB     = 4'd11,
    MSUBU    = 4'd12
  } mdu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mdu_state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // One bit per opcode: set when the opcode occupies the sequencer for several cycles.
`ifdef MDU_MADD_EN
  localparam logic [15:0] MULDIV_SET = 16'b0001_1110_0001_1110;
`else
  localparam logic [15:0] MULDIV_SET = 16'b0000_0000_0001_1110;
`endif

  function automatic logic is_muldiv(input logic [3:0] op);
    return MULDIV_SET[op];
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == DIV) || (op == DIVU);
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational 64-bit result generator for the latched MDU operation.
// wr is low when the operation must leave HI/LO untouched (divide by zero,
// or an opcode that does not produce a result).
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] res,
  output logic        wr
);

  logic [63:0] a_sx_s;
  logic [63:0] b_sx_s;
  logic [63:0] prod_s_s;
  logic [63:0] prod_u_s;
  logic [63:0] acc_s;
  logic [31:0] quo_s_s;
  logic [31:0] rem_s_s;
  logic [31:0] quo_u_s;
  logic [31:0] rem_u_s;

  // Signed division is done on 64-bit sign-extended operands, so
  // 0x80000000 / -1 yields 2^31 whose low word is 0x80000000 with remainder 0.
  assign a_sx_s   = {{32{a[31]}}, a};
  assign b_sx_s   = {{32{b[31]}}, b};
  assign prod_s_s = a_sx_s * b_sx_s;
  assign prod_u_s = {32'd0, a} * {32'd0, b};
  assign acc_s    = {hi, lo};
  assign quo_s_s  = 32'($signed(a_sx_s) / $signed(b_sx_s));
  assign rem_s_s  = 32'($signed(a_sx_s) % $signed(b_sx_s));
  assign quo_u_s  = a / b;
  assign rem_u_s  = a % b;

  // Select the result for the latched opcode; defaults keep HI/LO as they are.
  always_comb begin
    res = acc_s;
    wr  = 1'b0;
    case (mdu_op_e'(op))
      MULT: begin
        res = prod_s_s;
        wr  = 1'b1;
      end
      MULTU: begin
        res = prod_u_s;
        wr  = 1'b1;
      end
      DIV: begin
        if (b != 32'd0) begin
          res = {rem_s_s, quo_s_s};
          wr  = 1'b1;
        end else begin
          res = acc_s;
          wr  = 1'b0;
        end
      end
      DIVU: begin
        if (b != 32'd0) begin
          res = {rem_u_s, quo_u_s};
          wr  = 1'b1;
        end else begin
          res = acc_s;
          wr  = 1'b0;
        end
      end
      MADD: begin
        res = acc_s + prod_s_s;
        wr  = 1'b1;
      end
      MADDU: begin
        res = acc_s + prod_u_s;
        wr  = 1'b1;
      end
      MSUB: begin
        res = acc_s - prod_s_s;
        wr  = 1'b1;
      end
      MSUBU: begin
        res = acc_s - prod_u_s;
        wr  = 1'b1;
      end
      default: begin
        res = acc_s;
        wr  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mdu_seq.sv
// Multi-cycle multiply/divide sequencer for the E stage.
// Owns HI/LO, counts out the busy window of each mult/div and raises stall
// while an MDU-dependent instruction sits in E. A running operation is never
// cancelled by req; only a not-yet-accepted instruction is a flush victim.
// Optional build macro: MDU_MADD_EN (accepts madd/maddu/msub/msubu).
module mdu_seq
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic        md_use,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mdu_o
);

  localparam logic [4:0] MULT_CNT = 5'(MULT_CYCLES);
  localparam logic [4:0] DIV_CNT  = 5'(DIV_CYCLES);

  mdu_state_e  state_r;
  mdu_state_e  state_nx_s;
  logic [4:0]  cnt_r;
  logic [4:0]  cnt_nx_s;
  logic        busy_r;
  logic [3:0]  op_r;
  logic [31:0] a_r;
  logic [31:0] b_r;
  logic [31:0] hi_r;
  logic [31:0] lo_r;
  logic        accept_s;
  logic        load_s;
  logic        fin_s;
  logic [63:0] calc_res_s;
  logic        calc_wr_s;

  assign accept_s = start && !req && !busy_r;

  mdu_calc u_calc (
    .op  (op_r),
    .a   (a_r),
    .b   (b_r),
    .hi  (hi_r),
    .lo  (lo_r),
    .res (calc_res_s),
    .wr  (calc_wr_s)
  );

  // Next-state and counter logic: load on accept, count down, finish at 1.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    load_s     = 1'b0;
    fin_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s && is_muldiv(op)) begin
          state_nx_s = RUN;
          load_s     = 1'b1;
          if (is_div(op)) begin
            cnt_nx_s = DIV_CNT;
          end else begin
            cnt_nx_s = MULT_CNT;
          end
        end else begin
          state_nx_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r <= 5'd1) begin
          state_nx_s = IDLE;
          cnt_nx_s   = 5'd0;
          fin_s      = 1'b1;
        end else begin
          cnt_nx_s = cnt_r - 5'd1;
        end
      end
      default: begin
        state_nx_s = IDLE;
        cnt_nx_s   = 5'd0;
      end
    endcase
  end

  // State, counter and busy flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= 5'd0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
      busy_r  <= (state_nx_s == RUN);
    end
  end

  // Capture opcode and operands when a multi-cycle operation is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_r <= 4'd0;
      a_r  <= 32'd0;
      b_r  <= 32'd0;
    end else if (load_s) begin
      op_r <= op;
      a_r  <= rs;
      b_r  <= rt;
    end
  end

  // HI/LO update: completion result, or a direct move-to from rs.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_r <= 32'd0;
      lo_r <= 32'd0;
    end else if (fin_s && calc_wr_s) begin
      hi_r <= calc_res_s[63:32];
      lo_r <= calc_res_s[31:0];
    end else begin
      if (accept_s && (op == MTHI)) begin
        hi_r <= rs;
      end
      if (accept_s && (op == MTLO)) begin
        lo_r <= rs;
      end
    end
  end

  // A consumer stalls while busy, and already in the cycle a mult/div is issued.
  assign stall = md_use && (busy_r || (start && is_muldiv(op) && !req));

  // Move-from read port.
  always_comb begin
    mdu_o = 32'd0;
    if (op == MFHI) begin
      mdu_o = hi_r;
    end else if (op == MFLO) begin
      mdu_o = lo_r;
    end else begin
      mdu_o = 32'd0;
    end
  end

  assign busy = busy_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: directed cases plus randomized operations,
// with multi-cycle results checked by a scoreboard monitor on busy falling.
module tb_mdu_seq;
  import mdu_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        start;
  logic [3:0]  op;
  logic        md_use;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mdu_o;

  always #5 clk = ~clk;

  mdu_seq #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .start  (start),
    .op     (op),
    .md_use (md_use),
    .rs     (rs),
    .rt     (rt),
    .busy   (busy),
    .stall  (stall),
    .hi     (hi),
    .lo     (lo),
    .mdu_o  (mdu_o)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  exp_t        sbq[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Which opcodes occupy the unit for several cycles.
  function automatic bit ref_muldiv(input logic [3:0] o);
    case (o)
      MULT, MULTU, DIV, DIVU: return 1'b1;
`ifdef MDU_MADD_EN
      MADD, MADDU, MSUB, MSUBU: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic int ref_len(input logic [3:0] o);
    return (o == DIV || o == DIVU) ? DC : MC;
  endfunction

  // Architectural effect of one operation on HI/LO, in plain arithmetic.
  function automatic void ref_exec(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                   inout logic [31:0] h, inout logic [31:0] l);
    longint          sa, sb;
    longint unsigned ua, ub, acc;
    sa  = $signed(a);
    sb  = $signed(b);
    ua  = a;
    ub  = b;
    acc = {h, l};
    case (o)
      MULT:  {h, l} = sa * sb;
      MULTU: {h, l} = ua * ub;
      DIV: if (b != 32'd0) begin
        l = 32'(sa / sb);
        h = 32'(sa % sb);
      end
      DIVU: if (b != 32'd0) begin
        l = a / b;
        h = a % b;
      end
      MTHI: h = a;
      MTLO: l = a;
`ifdef MDU_MADD_EN
      MADD:  {h, l} = acc + sa * sb;
      MADDU: {h, l} = acc + ua * ub;
      MSUB:  {h, l} = acc - sa * sb;
      MSUBU: {h, l} = acc - ua * ub;
`endif
      default: ;
    endcase
  endfunction

  // Issue one instruction in E; hold start while the unit is busy.
  task automatic do_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit flush, input int req_at);
    bit   md;
    exp_t e;
    int   n;
    @(negedge clk);
    start = 1'b1; op = o; rs = a; rt = b; md_use = 1'b1; req = flush;
    #1;
    md = ref_muldiv(o) && !flush;
    check("stall_at_issue", stall, md);
    if (o == MFHI) check("mdu_o_mfhi", mdu_o, m_hi);
    else if (o == MFLO) check("mdu_o_mflo", mdu_o, m_lo);
    else check("mdu_o_zero", mdu_o, 32'd0);
    if (!flush) ref_exec(o, a, b, m_hi, m_lo);
    if (md) begin
      e.hi = m_hi; e.lo = m_lo; e.len = ref_len(o);
      sbq.push_back(e);
    end
    @(negedge clk);
    req = 1'b0;
    if (md) begin
      n = 0;
      while (busy === 1'b1 && n < 64) begin
        check("stall_while_busy", stall, 1'b1);
        req = (n == req_at);
        @(negedge clk);
        n++;
      end
      req = 1'b0;
      if (n >= 64) begin
        checks++; errors++;
        $display("FAIL busy_timeout: busy still high after %0d cycles, required low", n);
      end
    end else begin
      check("busy_idle", busy, 1'b0);
      check("hi_after", hi, m_hi);
      check("lo_after", lo, m_lo);
    end
    start = 1'b0; md_use = 1'b0; op = MDU_NONE; rs = 32'd0; rt = 32'd0;
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return 32'($urandom);
    endcase
  endfunction

  // Scoreboard monitor: a busy window ending means a result is due.
  initial begin : monitor
    int   run_len;
    exp_t e;
    run_len = 0;
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        run_len = 0;
      end else if (busy === 1'b1) begin
        run_len++;
      end else if (run_len > 0) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result: busy window of %0d with no pending op", run_len);
        end else begin
          e = sbq.pop_front();
          check("result_hi", hi, e.hi);
          check("result_lo", lo, e.lo);
          check("busy_len", run_len, e.len);
        end
        run_len = 0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    logic [3:0] o;
    reset = 1'b1; req = 1'b0; start = 1'b0; op = MDU_NONE; md_use = 1'b0; rs = 32'd0; rt = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_stall", stall, 1'b0);
    reset = 1'b0;

    do_op(MULT, 32'hFFFF_FFFF, 32'd2, 1'b0, -1);
    check("t1_hi", hi, 32'hFFFF_FFFF);
    check("t1_lo", lo, 32'hFFFF_FFFE);

    do_op(DIVU, 32'd7, 32'hFFFF_FFFF, 1'b0, -1);
    check("t2_divu_hi", hi, 32'd7);
    check("t2_divu_lo", lo, 32'd0);
    do_op(DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, -1);
    check("t2_div_hi", hi, 32'hFFFF_FFFF);
    check("t2_div_lo", lo, 32'hFFFF_FFFD);

    do_op(MULT, 32'd1234, 32'd5678, 1'b0, -1);
    do_op(MFLO, 32'd0, 32'd0, 1'b0, -1);
    check("t3_lo", lo, 32'd7006652);

    do_op(MULT, 32'd3, 32'd3, 1'b1, -1);
    do_op(MTLO, 32'hDEAD, 32'd0, 1'b1, -1);
    check("t4_lo_kept", lo, 32'd7006652);

    do_op(DIV, 32'd100, 32'd7, 1'b0, 2);
    check("t5_hi", hi, 32'd2);
    check("t5_lo", lo, 32'd14);

    do_op(MTHI, 32'h11, 32'd0, 1'b0, -1);
    do_op(MTLO, 32'h22, 32'd0, 1'b0, -1);
    do_op(DIV, 32'd5, 32'd0, 1'b0, -1);
    check("t6_hi", hi, 32'h11);
    check("t6_lo", lo, 32'h22);

    do_op(MTHI, 32'd0, 32'd0, 1'b0, -1);
    do_op(MTLO, 32'd1, 32'd0, 1'b0, -1);
    do_op(MADD, 32'd3, 32'd4, 1'b0, -1);
`ifdef MDU_MADD_EN
    check("t6_madd_lo", lo, 32'd13);
`else
    check("t6_madd_lo", lo, 32'd1);
`endif

    do_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, -1);
    check("ovf_hi", hi, 32'd0);
    check("ovf_lo", lo, 32'h8000_0000);

    for (int i = 0; i < 60; i++) begin
      o = 4'($urandom_range(0, 12));
      do_op(o, rnd_operand(), rnd_operand(), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8)) : -1);
    end

    // Reset in the middle of a running multiply.
    @(negedge clk);
    start = 1'b1; op = MULT; rs = 32'd5; rt = 32'd6; md_use = 1'b1;
    @(negedge clk);
    start = 1'b0; md_use = 1'b0; op = MDU_NONE;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rr_busy", busy, 1'b0);
    check("rr_hi", hi, 32'd0);
    check("rr_lo", lo, 32'd0);
    reset = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;

    do_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, -1);
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'd1);

    repeat (2) @(negedge clk);
    check("sb_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
Multi-cycle multiply/divide sequencer for the E stage of the 5-stage MIPS pipeline.
- Owns the HI/LO registers and runs mult/div operations over a fixed number of busy cycles.
- Raises a stall request to the hazard logic while E holds an MDU-dependent instruction.
- Honours the exception flush `req`, so a flushed MDU instruction never alters HI/LO.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (and madd/msub family when enabled); legal range 1..31.
DIV_CYCLES, 10, busy cycles for div/divu; legal range 1..31.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req  in  1  exception/interrupt flush; the instruction in E is cancelled
start  in  1  E stage holds a valid MDU instruction this cycle
op  in  4  MDU opcode (package enum)
md_use  in  1  E stage instruction is any MDU op (start/mfhi/mflo/mthi/mtlo)
rs  in  32  operand A (forwarded)
rt  in  32  operand B (forwarded)
busy  out  1  multi-cycle operation in progress
stall  out  1  stall request to F/D/E enable logic
hi  out  32  HI register
lo  out  32  LO register
mdu_o  out  32  mfhi → hi, mflo → lo, else 0 (combinational)

Behaviour:
- Reset: hi = 0, lo = 0, busy = 0, cnt = 0, state IDLE; stall = 0 after reset.
- Accept condition: `start && !req && !busy`. With req high the E instruction is a flush victim: nothing is latched, and there is no side effect on state, hi or lo.
- States: IDLE and RUN.
- IDLE → RUN on an accepted mult/multu/div/divu (or madd family):
  - operands latched;
  - cnt loaded with MULT_CYCLES or DIV_CYCLES;
  - busy = 1 from the next cycle.
- RUN:
  - cnt decrements each cycle;
  - when cnt reaches 1, hi/lo are written with the result and the state returns to IDLE;
  - busy = 1 for exactly N cycles after the start edge.
- mthi/mtlo:
  - accepted in IDLE when not flushed;
  - hi/lo written at the next edge;
  - no busy.
- An in-progress RUN is never aborted by req. The owning instruction has already left E and is older than the exception.
- stall = `md_use && (busy || (start && op is mult/div class && !req))`.
  - A consumer directly behind a start stalls, starting the same cycle the start is issued.
  - While stalled, the pipeline keeps start asserted. Start is ignored while busy, so there is no double issue.
- Arithmetic:
  - mult: signed 64-bit {hi,lo}.
  - multu: unsigned 64-bit {hi,lo}.
  - div: lo = signed quotient, hi = signed remainder (truncation toward zero; remainder takes the dividend's sign).
  - divu: unsigned quotient and remainder.
- Divide by zero: the op still takes DIV_CYCLES, and hi/lo are left unchanged.
- 0x80000000 / -1 (div): lo = 0x80000000, hi = 0.
- Reset during RUN: immediate return to IDLE with all registers cleared.

Optional Feature:
Macro MDU_MADD_EN.
- Defined: madd, maddu, msub and msubu are accepted. Each computes {hi,lo} ± product (signed/unsigned, 64-bit wrap) with MULT_CYCLES latency, accumulating on the hi/lo value present at completion.
- Undefined: those opcodes are treated as no-ops: no busy, no stall, no write.

Decomposition:
- Package mdu_pkg:
  - 4-bit op enum (MDU_NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO, MADD, MADDU, MSUB, MSUBU);
  - is_muldiv helper constant set;
  - default cycle constants.
- Sub-module mdu_calc: combinational 64-bit result from the latched op/operands, instantiated once.
- mdu_seq keeps the FSM, counter, and hi/lo registers.

Test Plan:
1. After reset: mult rs=0xFFFFFFFF (−1), rt=2 → busy high for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
2. divu rs=7, rt=0xFFFFFFFF is run first → hi=7, lo=0 after 10 cycles. Then div rs=−7, rt=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
3. mult immediately followed by mflo with md_use=1 → stall asserted from the mult start cycle until busy falls; mdu_o then equals the new lo.
4. start=1 (mult) with req=1 in the same cycle → busy stays 0 and hi/lo are unchanged. mtlo with req=1 → lo unchanged.
5. req pulses 2 cycles into a running div → operation completes with the correct hi/lo at cycle 10.
6. div rs=5, rt=0 with hi=0x11, lo=0x22 → busy for 10 cycles and hi/lo remain 0x11/0x22. With MDU_MADD_EN: hi=0, lo=1, then madd 3×4 → lo=13.
